// File: rtl/emsensor_array.sv
// Electromagnetic-fault sensor array: N duplicated-flop sensor cells, alarm
// synchronisers, masking, sticky capture, windowed event counter and trip FSM.

module sensor_cell (
  input  logic clk,
  input  logic rst_n,
  output logic q,
  output logic qs,
  output logic a
);
  logic q_q, q_d, qs_q, qs_d;

  // Two identical toggle flops; a fault that upsets only one shows as a mismatch.
  assign q_d  = ~q_q;
  assign qs_d = ~qs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q  <= 1'b0;
      qs_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      qs_q <= qs_d;
    end
  end

  assign q  = q_q;
  assign qs = qs_q;
  assign a  = q_q ^ qs_q;
endmodule

module emsensor_array #(
  parameter int N           = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int WIN_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     mask,
  input  logic [CNT_W-1:0] threshold,
  input  logic [WIN_W-1:0] window,
  input  logic             clr,
  output logic [N-1:0]     q,
  output logic [N-1:0]     qs,
  output logic [N-1:0]     alarm_sync,
  output logic [N-1:0]     alarm_sticky,
  output logic [CNT_W-1:0] event_cnt,
  output logic             trip,
  output logic             trip_pulse
);
  localparam int HIT_W = $clog2(N + 1);
  // Wide enough that a full popcount never wraps before saturation.
  localparam int SUM_W = ((CNT_W > HIT_W) ? CNT_W : HIT_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, TRIPPED} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [N-1:0]     alarm_sticky_q, alarm_sticky_d;
  logic             trip_pulse_q, trip_pulse_d;
  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [N-1:0]     sync_d [SYNC_STAGES];

  logic             cell_rst_n;
  logic [N-1:0]     cell_a;
  logic [HIT_W-1:0] hits;
  logic [CNT_W-1:0] base_cnt, cnt_sat;
  logic [WIN_W-1:0] win_base;
  logic [SUM_W-1:0] sum;
  logic             trip_hit, win_end;

  assign cell_rst_n = rst & en;

  for (genvar i = 0; i < N; i++) begin : g_cell
    sensor_cell u_cell (
      .clk   (clk),
      .rst_n (cell_rst_n),
      .q     (q[i]),
      .qs    (qs[i]),
      .a     (cell_a[i])
    );
  end

  always_comb begin
    sync_d[0] = cell_a;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
  end

  assign alarm_sync = sync_q[SYNC_STAGES-1] & mask;

  always_comb begin
    hits = '0;
    for (int i = 0; i < N; i++) hits = hits + HIT_W'(alarm_sync[i]);
  end

  // clr in the same cycle discards the old count and window position.
  assign base_cnt = clr ? '0 : event_cnt_q;
  assign win_base = clr ? '0 : win_cnt_q;
  assign sum      = SUM_W'(base_cnt) + SUM_W'(hits);
  assign cnt_sat  = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  assign trip_hit = (threshold != '0) && (sum >= SUM_W'(threshold));
  assign win_end  = (window != '0) && (win_base == window - WIN_W'(1));

  always_comb begin
    state_d        = state_q;
    event_cnt_d    = event_cnt_q;
    win_cnt_d      = win_cnt_q;
    trip_pulse_d   = 1'b0;
    alarm_sticky_d = clr ? alarm_sync : (alarm_sticky_q | alarm_sync);
    if (!en) begin
      state_d     = IDLE;
      event_cnt_d = '0;
      win_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = ARMED;
          event_cnt_d = '0;
          win_cnt_d   = '0;
        end
        ARMED: begin
          if (trip_hit) begin
            state_d      = TRIPPED;
            trip_pulse_d = 1'b1;
            event_cnt_d  = cnt_sat;
            win_cnt_d    = win_base + WIN_W'(1);
          end else if (win_end) begin
            event_cnt_d = '0;
            win_cnt_d   = '0;
          end else begin
            event_cnt_d = cnt_sat;
            win_cnt_d   = win_base + WIN_W'(1);
          end
        end
        TRIPPED: begin
          if (clr) begin
            state_d     = ARMED;
            event_cnt_d = '0;
            win_cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      event_cnt_q    <= '0;
      win_cnt_q      <= '0;
      alarm_sticky_q <= '0;
      trip_pulse_q   <= 1'b0;
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      state_q        <= state_d;
      event_cnt_q    <= event_cnt_d;
      win_cnt_q      <= win_cnt_d;
      alarm_sticky_q <= alarm_sticky_d;
      trip_pulse_q   <= trip_pulse_d;
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
    end
  end

  assign alarm_sticky = alarm_sticky_q;
  assign event_cnt    = event_cnt_q;
  assign trip         = (state_q == TRIPPED);
  assign trip_pulse   = trip_pulse_q;
endmodule

// File: tb/tb_emsensor_array.sv
// Bench for emsensor_array: directed scenarios plus random traffic, every cycle
// compared against a cycle-level behavioural model of the array.

module tb_emsensor_array;
  localparam int N  = 32;
  localparam int SS = 2;
  localparam int CW = 4;
  localparam int WW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, en, clr;
  logic [N-1:0]  mask;
  logic [CW-1:0] threshold;
  logic [WW-1:0] window;
  logic [N-1:0]  q, qs, alarm_sync, alarm_sticky;
  logic [CW-1:0] event_cnt;
  logic          trip, trip_pulse;
  logic [N-1:0]  a_drv;

  emsensor_array #(.N(N), .SYNC_STAGES(SS), .CNT_W(CW), .WIN_W(WW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mask         (mask),
    .threshold    (threshold),
    .window       (window),
    .clr          (clr),
    .q            (q),
    .qs           (qs),
    .alarm_sync   (alarm_sync),
    .alarm_sticky (alarm_sticky),
    .event_cnt    (event_cnt),
    .trip         (trip),
    .trip_pulse   (trip_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses_seen = 0;

  // model: raw alarm history, sticky word, count, window position, mode (0 idle, 1 armed, 2 tripped)
  logic [N-1:0] m_hist [SS];
  logic [N-1:0] m_sticky = '0;
  int m_cnt = 0, m_win = 0, m_mode = 0;
  bit m_pulse = 0, m_ph = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_a(input logic [N-1:0] v);
    a_drv = v;
    force dut.cell_a = a_drv;
  endtask

  task automatic model_edge();
    logic [N-1:0] s;
    int hits, base, wb, sum;
    s    = m_hist[SS-1] & mask;
    hits = $countones(s);
    m_sticky = clr ? s : (m_sticky | s);
    m_pulse  = 0;
    if (!en) begin
      m_mode = 0; m_cnt = 0; m_win = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_cnt = 0; m_win = 0;
    end else if (m_mode == 1) begin
      base = clr ? 0 : m_cnt;
      wb   = clr ? 0 : m_win;
      sum  = base + hits;
      if (threshold != 0 && sum >= int'(threshold)) begin
        m_mode = 2; m_pulse = 1;
        m_cnt = (sum > CMAX) ? CMAX : sum;
      end else if (window != 0 && wb == int'(window) - 1) begin
        m_cnt = 0; m_win = 0;
      end else begin
        m_cnt = (sum > CMAX) ? CMAX : sum;
        m_win = (wb + 1) % (1 << WW);
      end
    end else if (clr) begin
      m_mode = 1; m_cnt = 0; m_win = 0;
    end
    m_ph = en ? ~m_ph : 1'b0;
    for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = a_drv;
  endtask

  task automatic compare_all();
    check("alarm_sync", alarm_sync, m_hist[SS-1] & mask);
    check("alarm_sticky", alarm_sticky, m_sticky);
    check("event_cnt", event_cnt, m_cnt);
    check("trip", trip, m_mode == 2);
    check("trip_pulse", trip_pulse, m_pulse);
    check("q", q, {N{m_ph}});
    check("qs", qs, {N{m_ph}});
    if (trip_pulse) pulses_seen++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input logic [N-1:0] v);
    set_a(v);
    step();
    set_a('0);
  endtask

  task automatic clr_cycle();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < SS; k++) m_hist[k] = '0;
    rst = 1'b0; en = 1'b1; clr = 1'b0;
    mask = '1; threshold = '0; window = '0;
    set_a('1);
    // reset held with alarms forced: everything must stay at zero
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compare_all();
    end
    set_a('0);
    rst = 1'b1;
    step();
    check("post_reset_cnt", event_cnt, 0);

    // single-channel pulses, threshold 3, unbounded window
    threshold = 3; window = 0;
    pulses_seen = 0;
    pulse(32'h20);
    steps(3);
    check("s1_cnt_one", event_cnt, 1);
    check("s1_sticky", alarm_sticky, 32'h20);
    check("s1_no_trip", trip, 0);
    pulse(32'h20); steps(2);
    pulse(32'h20); steps(4);
    check("s1_trip", trip, 1);
    check("s1_cnt_three", event_cnt, 3);
    check("s1_one_pulse", pulses_seen, 1);

    // masked channel never counts
    clr_cycle();
    mask = 32'hFFFF_FFFE;
    for (int i = 0; i < 5; i++) begin
      pulse(32'h1);
      steps(2);
    end
    check("s2_cnt", event_cnt, 0);
    check("s2_sticky", alarm_sticky, 0);
    check("s2_no_trip", trip, 0);

    // windowed counting: two alarms per window at most
    mask = '1; threshold = 4; window = 10;
    clr_cycle();
    for (int i = 0; i < 8; i++) begin
      pulse(32'h8);
      steps(5);
    end
    check("s3_window_no_trip", trip, 0);
    window = 0;
    clr_cycle();
    for (int i = 0; i < 5; i++) begin
      pulse(32'h8);
      steps(5);
    end
    check("s3_unbounded_trip", trip, 1);

    // saturation with tripping disabled
    clr_cycle();
    threshold = 0;
    set_a('1);
    steps(2);
    set_a('0);
    steps(4);
    check("s4_saturate", event_cnt, CMAX);
    check("s4_no_trip", trip, 0);

    // clr while tripped, with a fresh alarm landing in the clr cycle
    clr_cycle();
    threshold = 1;
    pulse(32'h2);
    steps(3);
    check("s5_tripped", trip, 1);
    set_a(32'h4);
    step();
    set_a('0);
    step();
    clr_cycle();
    check("s5_sticky", alarm_sticky, 32'h4);
    check("s5_cnt", event_cnt, 0);
    check("s5_armed", trip, 0);
    step();
    en = 1'b0;
    steps(2);
    check("s5_idle_trip", trip, 0);
    check("s5_sticky_kept", alarm_sticky, 32'h4);
    en = 1'b1;
    steps(2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        mask      = ($urandom_range(0, 3) == 0) ? '1 : $urandom;
        threshold = CW'($urandom_range(0, CMAX));
        window    = WW'($urandom_range(0, 12));
      end
      en  = ($urandom_range(0, 29) != 0);
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0) set_a($urandom & $urandom & $urandom & $urandom);
      else set_a('0);
      step();
    end
    clr = 1'b0;
    set_a('0);
    steps(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
